// File: rtl/abm_pkg.sv
// rtl/abm_pkg.sv - shared widths and FSM state type for the approximate-multiplier error monitor
package abm_pkg;

    localparam int ABM_WIDTH  = 16;
    localparam int ABM_PROD_W = 2 * ABM_WIDTH;
    localparam int ABM_ED_W   = ABM_PROD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } abm_state_e;

endpackage

// File: rtl/abm_ed_pipe.sv
// rtl/abm_ed_pipe.sv - exact-product recompute and |approx - exact| pipeline with per-stage valids
module abm_ed_pipe #(
    parameter int WIDTH = abm_pkg::ABM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic [2*WIDTH-1:0]   approx_i,
    output logic                 pending_o,
    output logic                 ed_valid_o,
    output logic [2*WIDTH-1:0]   ed_o,
    output logic [WIDTH-1:0]     ed_a_o,
    output logic [WIDTH-1:0]     ed_b_o
);
    localparam int PW = 2 * WIDTH;

    logic              s0_v_q, s1_v_q, s2_v_q;
    logic [WIDTH-1:0]  s0_a_q, s0_b_q, s1_a_q, s1_b_q, s2_a_q, s2_b_q;
    logic [PW-1:0]     s0_p_q, s1_p_q, s1_exact_q, s2_ed_q;

    logic [PW-1:0]     exact_d;
    logic signed [PW:0] diff_d;
    logic [PW-1:0]     ed_d;

    always_comb begin
        exact_d = PW'(s0_a_q) * PW'(s0_b_q);
        diff_d  = $signed({1'b0, s1_p_q}) - $signed({1'b0, s1_exact_q});
        // Magnitude of a (PW+1)-bit difference of two PW-bit values always fits PW bits
        ed_d    = diff_d[PW] ? PW'(-diff_d) : diff_d[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_v_q     <= 1'b0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_p_q     <= '0;
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_p_q     <= '0;
            s1_exact_q <= '0;
            s2_v_q     <= 1'b0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s2_ed_q    <= '0;
        end else begin
            s0_v_q <= in_valid_i;
            if (in_valid_i) begin
                s0_a_q <= a_i;
                s0_b_q <= b_i;
                s0_p_q <= approx_i;
            end
            s1_v_q     <= s0_v_q;
            s1_a_q     <= s0_a_q;
            s1_b_q     <= s0_b_q;
            s1_p_q     <= s0_p_q;
            s1_exact_q <= exact_d;
            s2_v_q     <= s1_v_q;
            s2_a_q     <= s1_a_q;
            s2_b_q     <= s1_b_q;
            s2_ed_q    <= ed_d;
        end
    end

    // The last stage retires into the statistics on the next edge, so only earlier stages count as pending
    assign pending_o  = s0_v_q | s1_v_q;
    assign ed_valid_o = s2_v_q;
    assign ed_o       = s2_ed_q;
    assign ed_a_o     = s2_a_q;
    assign ed_b_o     = s2_b_q;

endmodule

// File: rtl/abm_error_monitor.sv
// rtl/abm_error_monitor.sv - windowed error-distance statistics collector for the approximate multiplier
module abm_error_monitor #(
    parameter int WIDTH        = abm_pkg::ABM_WIDTH,
    parameter int SAMPLES_LOG2 = 10,
    parameter int ACC_W        = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        multiplier,
    input  logic [WIDTH-1:0]        multiplicand,
    input  logic [2*WIDTH-1:0]      product,
    output logic                    busy,
    output logic                    done,
    output logic [SAMPLES_LOG2:0]   err_count,
    output logic [ACC_W-1:0]        sum_ed,
    output logic [2*WIDTH-1:0]      mean_ed,
    output logic [2*WIDTH-1:0]      max_ed,
    output logic [WIDTH-1:0]        worst_a,
    output logic [WIDTH-1:0]        worst_b
);
    import abm_pkg::*;

    localparam int PW = 2 * WIDTH;
    localparam int CW = SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << SAMPLES_LOG2) - 1);

    abm_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     err_q, err_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [PW-1:0]     max_q, max_d;
    logic [WIDTH-1:0]  wa_q, wa_d, wb_q, wb_d;

    logic              accept;
    logic              pending;
    logic              ed_valid;
    logic [PW-1:0]     ed;
    logic [WIDTH-1:0]  ed_a, ed_b;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;

    abm_ed_pipe #(.WIDTH(WIDTH)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (accept),
        .a_i        (multiplier),
        .b_i        (multiplicand),
        .approx_i   (product),
        .pending_o  (pending),
        .ed_valid_o (ed_valid),
        .ed_o       (ed),
        .ed_a_o     (ed_a),
        .ed_b_o     (ed_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        sum_d   = sum_q;
        max_d   = max_q;
        wa_d    = wa_q;
        wb_d    = wb_q;

        // The pipeline is empty in IDLE, so clearing on start never collides with a retiring sample
        if (ed_valid) begin
            sum_d = sum_q + ACC_W'(ed);
            err_d = err_q + CW'(ed != '0);
            if (ed > max_q) begin
                max_d = ed;
                wa_d  = ed_a;
                wb_d  = ed_b;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = '0;
                    sum_d   = '0;
                    max_d   = '0;
                    wa_d    = '0;
                    wb_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pending) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign mean_ed   = PW'(sum_q >> SAMPLES_LOG2);
    assign max_ed    = max_q;
    assign worst_a   = wa_q;
    assign worst_b   = wb_q;

endmodule

// File: tb/tb_abm_error_monitor.sv
// tb/tb_abm_error_monitor.sv - scoreboard bench for abm_error_monitor with a 4-sample window
module tb_abm_error_monitor;

    localparam int W  = 16;
    localparam int SL = 2;
    localparam int AW = 48;
    localparam int PW = 2 * W;
    localparam int CW = SL + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  multiplier = '0;
    logic [W-1:0]  multiplicand = '0;
    logic [PW-1:0] product = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] err_count;
    logic [AW-1:0] sum_ed;
    logic [PW-1:0] mean_ed;
    logic [PW-1:0] max_ed;
    logic [W-1:0]  worst_a;
    logic [W-1:0]  worst_b;

    abm_error_monitor #(.WIDTH(W), .SAMPLES_LOG2(SL), .ACC_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .sum_ed       (sum_ed),
        .mean_ed      (mean_ed),
        .max_ed       (max_ed),
        .worst_a      (worst_a),
        .worst_b      (worst_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] ec;
        logic [AW-1:0] sum;
        logic [PW-1:0] mean;
        logic [PW-1:0] mx;
        logic [W-1:0]  wa;
        logic [W-1:0]  wb;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    logic [W-1:0]  sa[4];
    logic [W-1:0]  sb[4];
    logic [PW-1:0] sp[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [CW-1:0] ec, input logic [AW-1:0] sum, input logic [PW-1:0] mean,
                            input logic [PW-1:0] mx, input logic [W-1:0] wa, input logic [W-1:0] wb);
        exp_t e;
        e.ec = ec; e.sum = sum; e.mean = mean; e.mx = mx; e.wa = wa; e.wb = wb;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected window result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("err_count", 64'(err_count), 64'(e.ec));
                chk("sum_ed",    64'(sum_ed),    64'(e.sum));
                chk("mean_ed",   64'(mean_ed),   64'(e.mean));
                chk("max_ed",    64'(max_ed),    64'(e.mx));
                chk("worst_a",   64'(worst_a),   64'(e.wa));
                chk("worst_b",   64'(worst_b),   64'(e.wb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic cyc(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
        in_valid     = v;
        multiplier   = a;
        multiplicand = b;
        product      = p;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Called right after the negedge following the last accept; done must rise exactly 3 edges after it
    task automatic expect_done(input bit extra);
        chk("in_ready_after_last", 64'(in_ready), 64'd0);
        if (extra) begin
            in_valid = 1'b1; multiplier = 16'd100; multiplicand = 16'd100; product = '0;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("done_timing_%0d", k), 64'(done), (k == 3) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_window(input int gaps, input bit extra);
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gaps; g++) cyc(1'b0, 16'hDEAD, 16'hBEEF, 32'h0);
            end
            cyc(1'b1, sa[i], sb[i], sp[i]);
        end
        expect_done(extra);
    endtask

    task automatic load_scn2();
        sa = '{16'd7, 16'd2, 16'd9, 16'd1};
        sb = '{16'd15, 16'd2, 16'd9, 16'd1};
        sp = '{32'd100, 32'd4, 32'd90, 32'd1};
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_sum_ed",   64'(sum_ed),   64'd0);
        chk("rst_max_ed",   64'(max_ed),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        // All-exact window
        sa = '{16'd3, 16'd5, 16'd0, 16'hFFFF};
        sb = '{16'd6, 16'd8, 16'd3, 16'hFFFF};
        sp = '{32'd18, 32'd40, 32'd0, 32'hFFFE0001};
        push_exp(3'd0, 48'd0, 32'd0, 32'd0, 16'd0, 16'd0);
        run_window(0, 1'b0);

        // Mixed errors: ed 5, 0, 9, 0
        load_scn2();
        push_exp(3'd2, 48'd14, 32'd3, 32'd9, 16'd9, 16'd9);
        run_window(0, 1'b0);

        // Extreme error distance
        sa = '{16'hFFFF, 16'd1, 16'd2, 16'd0};
        sb = '{16'hFFFF, 16'd1, 16'd3, 16'd0};
        sp = '{32'd0, 32'd1, 32'd6, 32'd0};
        push_exp(3'd1, 48'hFFFE0001, 32'h3FFF8000, 32'hFFFE0001, 16'hFFFF, 16'hFFFF);
        run_window(0, 1'b0);

        // Gaps in in_valid and extra offered samples after the window closes
        load_scn2();
        push_exp(3'd2, 48'd14, 32'd3, 32'd9, 16'd9, 16'd9);
        run_window(2, 1'b1);

        // start pulsed mid-RUN is ignored
        load_scn2();
        push_exp(3'd2, 48'd14, 32'd3, 32'd9, 16'd9, 16'd9);
        pulse_start();
        cyc(1'b1, sa[0], sb[0], sp[0]);
        cyc(1'b1, sa[1], sb[1], sp[1]);
        start = 1'b1;
        cyc(1'b0, 16'd0, 16'd0, 32'd0);
        start = 1'b0;
        chk("busy_after_ignored_start", 64'(busy), 64'd1);
        cyc(1'b1, sa[2], sb[2], sp[2]);
        cyc(1'b1, sa[3], sb[3], sp[3]);
        expect_done(1'b0);

        // Abort mid-window with asynchronous reset
        pulse_start();
        cyc(1'b1, 16'd7, 16'd15, 32'd100);
        cyc(1'b1, 16'd2, 16'd2, 32'd4);
        repeat (3) cyc(1'b0, 16'd0, 16'd0, 32'd0);
        chk("partial_sum_before_abort", 64'(sum_ed), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",      64'(busy),      64'd0);
        chk("abort_in_ready",  64'(in_ready),  64'd0);
        chk("abort_sum_ed",    64'(sum_ed),    64'd0);
        chk("abort_err_count", 64'(err_count), 64'd0);
        chk("abort_max_ed",    64'(max_ed),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie on ed=5: earliest sample keeps worst operands
        sa = '{16'd2, 16'd4, 16'd1, 16'd1};
        sb = '{16'd3, 16'd5, 16'd1, 16'd1};
        sp = '{32'd11, 32'd15, 32'd1, 32'd1};
        push_exp(3'd2, 48'd10, 32'd2, 32'd5, 16'd2, 16'd3);
        run_window(0, 1'b0);

        repeat (3) @(negedge clk);
        chk("hold_sum_ed",  64'(sum_ed),  64'd10);
        chk("hold_worst_a", 64'(worst_a), 64'd2);
        chk("hold_done",    64'(done),    64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
